// File: rtl/conv_10_sdiv_seq_1ckb.sv
// Sequential signed radix-2 restoring divider: 24-bit dividend / 8-bit divisor
// -> saturated 16-bit quotient and 8-bit remainder, ap_start/ap_done handshake.
module conv_10_sdiv_seq_1ckb #(
    parameter int ID         = 32'd1,
    parameter int din0_WIDTH = 32'd24,
    parameter int din1_WIDTH = 32'd8,
    parameter int dout_WIDTH = 32'd16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic signed [din0_WIDTH-1:0]  din0,
    input  logic signed [din1_WIDTH-1:0]  din1,
    output logic signed [dout_WIDTH-1:0]  dout,
    output logic signed [din1_WIDTH-1:0]  rem,
    output logic                          div_zero,
    output logic                          ovf
);

    localparam int CW = $clog2(din0_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [din0_WIDTH-1:0]   dvd;
    logic [din0_WIDTH-1:0]   quo;
    logic [din1_WIDTH-1:0]   dsr;
    logic [din1_WIDTH:0]     prem;
    logic                    sign_q;
    logic                    sign_r;
    logic                    dz;

    logic [din0_WIDTH-1:0]      a_mag;
    logic [din1_WIDTH-1:0]      b_mag;
    logic [din1_WIDTH+1:0]      shifted;
    logic [din1_WIDTH+1:0]      trial;
    logic signed [din0_WIDTH:0] qs;
    logic signed [din1_WIDTH-1:0] rs;

    // Returns {ovf, value}: in range when every bit above the dout sign bit matches it.
    function automatic logic [dout_WIDTH:0] sat_q(input logic signed [din0_WIDTH:0] v);
        logic [din0_WIDTH-dout_WIDTH+1:0] top;
        top = v[din0_WIDTH:dout_WIDTH-1];
        if ((&top) || !(|top))
            return {1'b0, v[dout_WIDTH-1:0]};
        else if (v[din0_WIDTH])
            return {1'b1, 1'b1, {(dout_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(dout_WIDTH-1){1'b1}}};
    endfunction

    // Two's-complement negation of the most negative value yields its unsigned magnitude.
    assign a_mag   = din0[din0_WIDTH-1] ? -din0 : din0;
    assign b_mag   = din1[din1_WIDTH-1] ? -din1 : din1;
    assign shifted = {prem, dvd[din0_WIDTH-1]};
    assign trial   = shifted - {2'b00, dsr};
    assign qs      = sign_q ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
    assign rs      = sign_r ? -$signed(prem[din1_WIDTH-1:0]) : $signed(prem[din1_WIDTH-1:0]);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ap_idle  <= 1'b1;
            ap_done  <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state   <= CALC;
                        cnt     <= '0;
                        ap_idle <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(din0_WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (dz) begin
                        dout     <= sign_r ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                           : {1'b0, {(dout_WIDTH-1){1'b1}}};
                        rem      <= '0;
                        div_zero <= 1'b1;
                        ovf      <= 1'b0;
                    end else begin
                        {ovf, dout} <= sat_q(qs);
                        rem         <= rs;
                        div_zero    <= 1'b0;
                    end
                    ap_done <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    ap_idle <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge ap_clk) begin
        case (state)
            IDLE: begin
                if (ap_start) begin
                    dvd    <= a_mag;
                    dsr    <= b_mag;
                    sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                    sign_r <= din0[din0_WIDTH-1];
                    dz     <= (din1 == '0);
                    prem   <= '0;
                    quo    <= '0;
                end
            end
            CALC: begin
                dvd  <= dvd << 1;
                prem <= trial[din1_WIDTH+1] ? shifted[din1_WIDTH:0] : trial[din1_WIDTH:0];
                quo  <= {quo[din0_WIDTH-2:0], ~trial[din1_WIDTH+1]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_10_sdiv_seq_1ckb.sv
// Self-checking bench for conv_10_sdiv_seq_1ckb against an integer-arithmetic model.
module tb_conv_10_sdiv_seq_1ckb;

    logic               ap_clk;
    logic               ap_rst;
    logic               ap_start;
    logic               ap_idle;
    logic               ap_done;
    logic signed [23:0] din0;
    logic signed [7:0]  din1;
    logic signed [15:0] dout;
    logic signed [7:0]  rem;
    logic               div_zero;
    logic               ovf;

    int total = 0;
    int bad   = 0;

    conv_10_sdiv_seq_1ckb dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference: C-style truncating division, remainder follows dividend, 16-bit saturation.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output bit z, output bit v);
        int qq;
        z = 1'b0; v = 1'b0; r = 0;
        if (b == 0) begin
            z = 1'b1;
            q = (a >= 0) ? 32767 : -32768;
        end else begin
            qq = a / b;
            r  = a % b;
            q  = qq;
            if (qq > 32767) begin q = 32767; v = 1'b1; end
            else if (qq < -32768) begin q = -32768; v = 1'b1; end
        end
    endfunction

    // Waits for idle, issues one request, scrambles inputs afterwards, returns ap_done cycle index.
    task automatic run_op(input int a, input int b, output int lat);
        int n = 0;
        while (!ap_idle && n < 100) begin @(negedge ap_clk); n++; end
        din0 = 24'(a); din1 = 8'(b); ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        din0 = 24'($urandom); din1 = 8'($urandom);
        lat = 1;
        while (!ap_done && lat < 100) begin @(negedge ap_clk); lat++; end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(negedge ap_clk);
        total++;
        if ({ap_idle, ap_done, dout, rem, div_zero, ovf} !== {1'b1, 1'b0, 16'sd0, 8'sd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset idle=%b done=%b dout=%0d rem=%0d dz=%b ovf=%b want idle=1 rest 0",
                     ap_idle, ap_done, dout, rem, div_zero, ovf);
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic test_arith();
        int ta[9] = '{-3000, -7, 7, 6000, -128, 8388607, -8388608, -8388608, 100000};
        int tb[9] = '{-3, 2, -2, -25, -128, 1, -1, 127, 3};
        int q, r, lat; bit z, v;
        for (int i = 0; i < 9; i++) begin
            model(ta[i], tb[i], q, r, z, v);
            run_op(ta[i], tb[i], lat);
            total += 5;
            if (lat != 26) begin bad++; $display("FAIL arith %0d/%0d latency got=%0d want=26", ta[i], tb[i], lat); end
            if (dout !== 16'(q)) begin bad++; $display("FAIL arith %0d/%0d dout got=%0d want=%0d", ta[i], tb[i], dout, q); end
            if (rem !== 8'(r)) begin bad++; $display("FAIL arith %0d/%0d rem got=%0d want=%0d", ta[i], tb[i], rem, r); end
            if (ovf !== v) begin bad++; $display("FAIL arith %0d/%0d ovf got=%b want=%b", ta[i], tb[i], ovf, v); end
            if (div_zero !== z) begin bad++; $display("FAIL arith %0d/%0d div_zero got=%b want=%b", ta[i], tb[i], div_zero, z); end
        end
    endtask

    task automatic test_div_zero();
        int ta[3] = '{500, -500, -8388608};
        int q, r, lat; bit z, v;
        for (int i = 0; i < 3; i++) begin
            model(ta[i], 0, q, r, z, v);
            run_op(ta[i], 0, lat);
            total += 5;
            if (lat != 26) begin bad++; $display("FAIL divzero %0d latency got=%0d want=26", ta[i], lat); end
            if (dout !== 16'(q)) begin bad++; $display("FAIL divzero %0d dout got=%0d want=%0d", ta[i], dout, q); end
            if (rem !== 8'(r)) begin bad++; $display("FAIL divzero %0d rem got=%0d want=%0d", ta[i], rem, r); end
            if (ovf !== v) begin bad++; $display("FAIL divzero %0d ovf got=%b want=%b", ta[i], ovf, v); end
            if (div_zero !== z) begin bad++; $display("FAIL divzero %0d div_zero got=%b want=%b", ta[i], div_zero, z); end
        end
    endtask

    task automatic test_random();
        int a, b, q, r, lat; bit z, v;
        logic signed [23:0] ra;
        logic signed [7:0]  rb;
        for (int i = 0; i < 40; i++) begin
            ra = 24'($urandom); rb = 8'($urandom);
            a = (i % 2 == 0) ? int'(ra) : int'($urandom_range(0, 200000)) - 100000;
            b = (i % 8 == 7) ? 0 : int'(rb);
            model(a, b, q, r, z, v);
            run_op(a, b, lat);
            total += 5;
            if (lat != 26) begin bad++; $display("FAIL random %0d/%0d latency got=%0d want=26", a, b, lat); end
            if (dout !== 16'(q)) begin bad++; $display("FAIL random %0d/%0d dout got=%0d want=%0d", a, b, dout, q); end
            if (rem !== 8'(r)) begin bad++; $display("FAIL random %0d/%0d rem got=%0d want=%0d", a, b, rem, r); end
            if (ovf !== v) begin bad++; $display("FAIL random %0d/%0d ovf got=%b want=%b", a, b, ovf, v); end
            if (div_zero !== z) begin bad++; $display("FAIL random %0d/%0d div_zero got=%b want=%b", a, b, div_zero, z); end
        end
    endtask

    task automatic test_back_to_back();
        int q1, r1, q2, r2, cyc, d1, d2, n; bit z1, v1, z2, v2;
        model(-1234567, 77, q1, r1, z1, v1);
        model(99999, -13, q2, r2, z2, v2);
        n = 0;
        while (!ap_idle && n < 100) begin @(negedge ap_clk); n++; end
        din0 = -24'sd1234567; din1 = 8'sd77; ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        din0 = 24'sd99999; din1 = -8'sd13;
        cyc = 1; d1 = -1; d2 = -1;
        while (d2 < 0 && cyc < 200) begin
            if (ap_done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    total += 2;
                    if (dout !== 16'(q1)) begin bad++; $display("FAIL b2b first dout got=%0d want=%0d", dout, q1); end
                    if (rem !== 8'(r1)) begin bad++; $display("FAIL b2b first rem got=%0d want=%0d", rem, r1); end
                end else begin
                    d2 = cyc;
                    ap_start = 1'b0;
                    total += 2;
                    if (dout !== 16'(q2)) begin bad++; $display("FAIL b2b second dout got=%0d want=%0d", dout, q2); end
                    if (rem !== 8'(r2)) begin bad++; $display("FAIL b2b second rem got=%0d want=%0d", rem, r2); end
                end
            end
            @(negedge ap_clk); cyc++;
        end
        ap_start = 1'b0;
        total += 2;
        if (d1 != 26) begin bad++; $display("FAIL b2b first latency got=%0d want=26", d1); end
        if (d2 - d1 != 27) begin bad++; $display("FAIL b2b spacing got=%0d want=27", d2 - d1); end
    endtask

    task automatic test_ignore_start();
        int q0, r0, q, r, lat, n; bit z0, v0, z, v, hold_bad;
        model(-30000, 7, q0, r0, z0, v0);
        model(4567, -9, q, r, z, v);
        run_op(-30000, 7, lat);
        n = 0;
        while (!ap_idle && n < 100) begin @(negedge ap_clk); n++; end
        din0 = 24'sd4567; din1 = -8'sd9; ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        lat = 1; hold_bad = 1'b0;
        while (!ap_done && lat < 100) begin
            ap_start = (lat == 3 || lat == 7 || lat == 12 || lat == 20);
            din0 = 24'($urandom); din1 = 8'($urandom);
            if (dout !== 16'(q0) || rem !== 8'(r0) || ovf !== v0 || div_zero !== z0) hold_bad = 1'b1;
            @(negedge ap_clk); lat++;
        end
        ap_start = 1'b0;
        total += 4;
        if (hold_bad) begin bad++; $display("FAIL hold outputs changed before ap_done got=1 want=0"); end
        if (lat != 26) begin bad++; $display("FAIL ignore latency got=%0d want=26", lat); end
        if (dout !== 16'(q) || rem !== 8'(r)) begin
            bad++; $display("FAIL ignore result got=%0d,%0d want=%0d,%0d", dout, rem, q, r);
        end
        repeat (4) @(negedge ap_clk);
        if (ap_idle !== 1'b1) begin bad++; $display("FAIL ignore queued start idle got=%b want=1", ap_idle); end
    endtask

    task automatic test_reset_mid();
        int lat, n; bit seen;
        n = 0;
        while (!ap_idle && n < 100) begin @(negedge ap_clk); n++; end
        din0 = 24'sd1000000; din1 = 8'sd3; ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (9) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        total++;
        if ({ap_idle, ap_done, dout, rem, div_zero, ovf} !== {1'b1, 1'b0, 16'sd0, 8'sd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset idle=%b done=%b dout=%0d rem=%0d dz=%b ovf=%b want idle=1 rest 0",
                     ap_idle, ap_done, dout, rem, div_zero, ovf);
        end
        ap_rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin @(negedge ap_clk); if (ap_done) seen = 1'b1; end
        total++;
        if (seen) begin bad++; $display("FAIL midreset stray ap_done got=1 want=0"); end
        run_op(100, 7, lat);
        total += 3;
        if (lat != 26) begin bad++; $display("FAIL midreset 100/7 latency got=%0d want=26", lat); end
        if (dout !== 16'sd14) begin bad++; $display("FAIL midreset 100/7 dout got=%0d want=14", dout); end
        if (rem !== 8'sd2) begin bad++; $display("FAIL midreset 100/7 rem got=%0d want=2", rem); end
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
        test_reset();
        test_arith();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
